// File: rtl/jtag_seq_pkg.sv
// Shared types and tms patterns for the host-side JTAG sequencer.
// Patterns are launched MSB first.
package jtag_seq_pkg;

  typedef enum logic [1:0] {
    OP_RESET    = 2'd0,
    OP_SHIFT_IR = 2'd1,
    OP_SHIFT_DR = 2'd2,
    OP_RUNIDLE  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_READY,
    ST_PRE,
    ST_SHIFT,
    ST_POST,
    ST_RUN
  } state_e;

  localparam logic [2:0] DR_PRE = 3'b100;
  localparam logic [3:0] IR_PRE = 4'b1100;
  localparam logic [1:0] POST   = 2'b10;
  localparam logic [5:0] RST    = 6'b111110;

  // Patterns are left-justified in 6 bits so one index form fits all.
  function automatic logic pat_bit(
    logic [5:0] pat,
    logic [2:0] i
  );
    return pat[3'd5 - i];
  endfunction

  function automatic logic [5:0] pre_pat(op_e op);
    unique case (op)
      OP_RESET:    return RST;
      OP_SHIFT_IR: return {IR_PRE, 2'b00};
      default:     return {DR_PRE, 3'b000};
    endcase
  endfunction

  function automatic logic [2:0] pre_len(op_e op);
    unique case (op)
      OP_RESET:    return 3'd6;
      OP_SHIFT_IR: return 3'd4;
      default:     return 3'd3;
    endcase
  endfunction

  function automatic logic is_shift(op_e op);
    return (op == OP_SHIFT_IR) || (op == OP_SHIFT_DR);
  endfunction

endpackage

// File: rtl/jtag_seq_shifter.sv
// tdi/tdo shift register: LSB goes out on tdi, tdo enters at the MSB,
// result is right-aligned when the command completes.
module jtag_seq_shifter #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               tck,
  input  logic               trst,
  input  logic               load,
  input  logic [MAX_LEN-1:0] load_data,
  input  logic               shift_en,
  input  logic               tdo,
  input  logic               done,
  input  logic [LEN_W-1:0]   len,
  output logic               tdi_bit,
  output logic [MAX_LEN-1:0] rsp_data
);

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] sreg;
  logic [LEN_W-1:0]   shamt;

  assign shamt   = MAX_L - len;
  assign tdi_bit = sreg[0];

  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      sreg     <= '0;
      rsp_data <= '0;
    end else begin
      if (load)
        sreg <= load_data;
      else if (shift_en)
        sreg <= {tdo, sreg[MAX_LEN-1:1]};
      if (done)
        rsp_data <= sreg >> shamt;
    end
  end

endmodule

// File: rtl/jtag_sequencer.sv
// Host-side JTAG master: turns TAP commands into tms/tdi streams
// and collects tdo. All state changes on the falling tck edge.
module jtag_sequencer
  import jtag_seq_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               tck,
  input  logic               trst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);

  state_e           state, state_n;
  op_e              op_q, op_n, op_in;
  logic [2:0]       pcnt, pcnt_n;
  logic [LEN_W-1:0] scnt, scnt_n;
  logic [LEN_W-1:0] len_q, len_n, len_c;
  logic             tms_q, tms_n;
  logic             ready_q, ready_n;
  logic             rsp_q, rsp_n;
  logic             idle, load, shift_en, sh_bit;

  assign op_in    = op_e'(cmd_op);
  assign len_c    = (cmd_len > MAX_L) ? MAX_L : cmd_len;
  assign shift_en = (state == ST_SHIFT);

  assign tms       = tms_q;
  assign tdi       = shift_en & sh_bit;
  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_q;

  always_comb begin
    state_n = state;
    op_n    = op_q;
    len_n   = len_q;
    pcnt_n  = pcnt;
    scnt_n  = scnt;
    tms_n   = tms_q;
    ready_n = 1'b0;
    rsp_n   = 1'b0;
    idle    = 1'b0;
    load    = 1'b0;
    unique case (state)
      ST_INIT: begin
        if (pcnt < 3'd6) begin
          tms_n  = pat_bit(RST, pcnt);
          pcnt_n = pcnt + 3'd1;
        end else begin
          idle = 1'b1;
        end
      end
      ST_READY: idle = 1'b1;
      ST_PRE: begin
        if (pcnt < pre_len(op_q)) begin
          tms_n  = pat_bit(pre_pat(op_q), pcnt);
          pcnt_n = pcnt + 3'd1;
        end else if (op_q == OP_RESET) begin
          idle = 1'b1;
        end else begin
          state_n = ST_SHIFT;
          tms_n   = (len_q == ONE);
          scnt_n  = ONE;
        end
      end
      ST_SHIFT: begin
        if (scnt < len_q) begin
          tms_n  = (scnt == len_q - ONE);
          scnt_n = scnt + ONE;
        end else begin
          state_n = ST_POST;
          tms_n   = pat_bit({POST, 4'b0000}, 3'd0);
          pcnt_n  = 3'd1;
        end
      end
      ST_POST: begin
        if (pcnt < 3'd2) begin
          tms_n  = pat_bit({POST, 4'b0000}, pcnt);
          pcnt_n = pcnt + 3'd1;
        end else begin
          idle  = 1'b1;
          rsp_n = 1'b1;
        end
      end
      ST_RUN: begin
        if (scnt < len_q) begin
          tms_n  = 1'b0;
          scnt_n = scnt + ONE;
        end else begin
          idle  = 1'b1;
          rsp_n = is_shift(op_q);
        end
      end
      default: state_n = ST_INIT;
    endcase
    // Completion edges accept directly so commands run back to back.
    if (idle) begin
      if (cmd_valid) begin
        load   = 1'b1;
        op_n   = op_in;
        len_n  = len_c;
        pcnt_n = 3'd1;
        scnt_n = LEN_W'(len_c != '0);
        unique case (1'b1)
          op_in == OP_RESET,
          is_shift(op_in) && (len_c != '0): begin
            state_n = ST_PRE;
            tms_n   = pat_bit(pre_pat(op_in), 3'd0);
          end
          default: begin
            state_n = ST_RUN;
            tms_n   = 1'b0;
          end
        endcase
      end else begin
        state_n = ST_READY;
        tms_n   = 1'b0;
        ready_n = 1'b1;
      end
    end
  end

  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      state   <= ST_INIT;
      op_q    <= OP_RESET;
      len_q   <= '0;
      pcnt    <= '0;
      scnt    <= '0;
      tms_q   <= 1'b1;
      ready_q <= 1'b0;
      rsp_q   <= 1'b0;
    end else begin
      state   <= state_n;
      op_q    <= op_n;
      len_q   <= len_n;
      pcnt    <= pcnt_n;
      scnt    <= scnt_n;
      tms_q   <= tms_n;
      ready_q <= ready_n;
      rsp_q   <= rsp_n;
    end
  end

  jtag_seq_shifter #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shifter (
    .tck       (tck),
    .trst      (trst),
    .load      (load),
    .load_data (cmd_data),
    .shift_en  (shift_en),
    .tdo       (tdo),
    .done      (rsp_n),
    .len       (len_q),
    .tdi_bit   (sh_bit),
    .rsp_data  (rsp_data)
  );

endmodule

// File: tb/tb_jtag_sequencer.sv
// Bench for jtag_sequencer: commands checked against a sequence-level
// model that builds whole tms/tdi/response streams from the command.
module tb_jtag_sequencer;

  logic        tck = 1'b1;
  logic        trst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [5:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        tdo = 1'b0;
  logic        cmd_ready, rsp_valid, tms, tdi;
  logic [31:0] rsp_data;

  int checks = 0;
  int errors = 0;

  int          ncyc, nrsp_mid;
  logic [63:0] o_tms, o_tdi;
  logic        rv_done, rv_after, rdy_after;
  logic [31:0] rd_done;

  int          e_ncyc;
  logic [63:0] e_tms, e_tdi, tdo_pat;
  logic        e_rv;
  logic [31:0] e_rsp;
  logic [31:0] last_rsp = '0;

  jtag_sequencer #(.MAX_LEN(32), .LEN_W(6)) dut (
    .tck       (tck),
    .trst      (trst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  always #5 tck = ~tck;

  task automatic step();
    @(negedge tck);
    #1;
  endtask

  // Expected streams, indexed by cycle number from the accepting edge.
  task automatic model(input int op, input int len,
                       input logic [31:0] data);
    int l, pre;
    l = (len > 32) ? 32 : len;
    e_tms = '0;
    e_tdi = '0;
    e_rv  = (op == 1) || (op == 2);
    e_rsp = last_rsp;
    if (op == 0) begin
      e_tms  = 64'h1f;
      e_ncyc = 6;
    end else if (op == 3 || l == 0) begin
      e_ncyc = (l == 0) ? 1 : l;
      if (e_rv) e_rsp = '0;
    end else begin
      pre = (op == 1) ? 4 : 3;
      e_tms[0] = 1'b1;
      if (op == 1) e_tms[1] = 1'b1;
      e_tms[pre+l-1] = 1'b1;
      e_tms[pre+l]   = 1'b1;
      e_ncyc = pre + l + 2;
      e_rsp  = '0;
      for (int k = 0; k < l; k++) begin
        e_tdi[pre+k] = data[k];
        e_rsp[k]     = tdo_pat[pre+k];
      end
    end
    if (e_rv) last_rsp = e_rsp;
  endtask

  task automatic run_cmd(input int op, input int len,
                         input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op[1:0];
    cmd_len   = len[5:0];
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_len   = 6'($urandom);
    cmd_data  = $urandom;
    ncyc = 0;
    nrsp_mid = 0;
    o_tms = '0;
    o_tdi = '0;
    while (cmd_ready !== 1'b1 && ncyc < 64) begin
      o_tms[ncyc] = tms;
      o_tdi[ncyc] = tdi;
      if (rsp_valid) nrsp_mid++;
      tdo = tdo_pat[ncyc];
      step();
      ncyc++;
    end
    rv_done = rsp_valid;
    rd_done = rsp_data;
    step();
    rv_after  = rsp_valid;
    rdy_after = cmd_ready;
  endtask

  task automatic do_init(output logic [63:0] seq, output int nrdy,
                         output int nrv);
    seq = '0;
    nrdy = 0;
    nrv = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      seq[i] = tms;
      if (cmd_ready) nrdy++;
      if (rsp_valid) nrv++;
    end
    step();
  endtask

  task automatic test_reset();
    logic [63:0] seq;
    int nrdy, nrv;
    step();
    trst = 1'b0;
    last_rsp = '0;
    #1;
    checks++;
    if ({tms, tdi, cmd_ready, rsp_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_outs: got %b want 1000",
               {tms, tdi, cmd_ready, rsp_valid});
    end
    checks++;
    if (rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp: got %h want 0", rsp_data);
    end
    step();
    step();
    trst = 1'b1;
    do_init(seq, nrdy, nrv);
    checks++;
    if (seq !== 64'h1f || nrdy != 0 || nrv != 0) begin
      errors++;
      $display("FAIL init_seq: tms %h rdy %0d rv %0d want 1f 0 0",
               seq, nrdy, nrv);
    end
    checks++;
    if ({cmd_ready, tms, rsp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL init_ready: got %b want 100",
               {cmd_ready, tms, rsp_valid});
    end
  endtask

  task automatic test_shift_ir();
    tdo_pat = {$urandom, $urandom};
    model(1, 3, 32'b010);
    run_cmd(1, 3, 32'b010);
    checks++;
    if (ncyc != 9 || o_tms !== 64'hc3) begin
      errors++;
      $display("FAIL ir_tms: cyc %0d tms %h want 9 c3", ncyc, o_tms);
    end
    checks++;
    if (o_tdi !== 64'h20) begin
      errors++;
      $display("FAIL ir_tdi: got %h want 20", o_tdi);
    end
    checks++;
    if (nrsp_mid != 0 || rv_done !== 1'b1 || rv_after !== 1'b0) begin
      errors++;
      $display("FAIL ir_rsp_pulse: mid %0d done %b after %b",
               nrsp_mid, rv_done, rv_after);
    end
    checks++;
    if (rd_done !== e_rsp) begin
      errors++;
      $display("FAIL ir_rsp_data: got %h want %h", rd_done, e_rsp);
    end
  endtask

  task automatic test_shift_dr();
    tdo_pat = {$urandom, $urandom};
    tdo_pat[7:3] = 5'b10110;
    model(2, 5, 32'h0);
    run_cmd(2, 5, 32'h0);
    checks++;
    if (ncyc != 10 || o_tms !== 64'h181) begin
      errors++;
      $display("FAIL dr_tms: cyc %0d tms %h want 10 181", ncyc, o_tms);
    end
    checks++;
    if (rd_done !== 32'h16 || rv_done !== 1'b1) begin
      errors++;
      $display("FAIL dr_rsp: got %h v%b want 00000016 v1",
               rd_done, rv_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int nrdy;
    d = $urandom;
    tdo_pat = {$urandom, $urandom};
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_len   = 6'd4;
    cmd_data  = $urandom;
    step();
    cmd_op   = 2'd2;
    cmd_len  = 6'd1;
    cmd_data = d;
    ncyc = 0;
    nrdy = 0;
    o_tms = '0;
    o_tdi = '0;
    while (ncyc < 10) begin
      o_tms[ncyc] = tms;
      o_tdi[ncyc] = tdi;
      if (cmd_ready) nrdy++;
      tdo = tdo_pat[ncyc];
      step();
      ncyc++;
      if (ncyc == 4) cmd_valid = 1'b0;
    end
    checks++;
    if (o_tms !== 64'h190 || nrdy != 0) begin
      errors++;
      $display("FAIL b2b_tms: tms %h rdy %0d want 190 0", o_tms, nrdy);
    end
    checks++;
    if (o_tdi !== (64'(d[0]) << 7)) begin
      errors++;
      $display("FAIL b2b_tdi: got %h want %h", o_tdi, 64'(d[0]) << 7);
    end
    last_rsp = {31'h0, tdo_pat[7]};
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b11 || rsp_data !== last_rsp) begin
      errors++;
      $display("FAIL b2b_done: rdy %b rv %b rsp %h want 1 1 %h",
               cmd_ready, rsp_valid, rsp_data, last_rsp);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulse: rsp_valid %b want 0", rsp_valid);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] d;
    d = $urandom;
    tdo_pat = {$urandom, $urandom};
    model(2, 40, d);
    run_cmd(2, 40, d);
    checks++;
    if (ncyc != 37 || o_tms !== e_tms || o_tdi !== e_tdi) begin
      errors++;
      $display("FAIL clamp_seq: cyc %0d tms %h tdi %h want %0d %h %h",
               ncyc, o_tms, o_tdi, e_ncyc, e_tms, e_tdi);
    end
    checks++;
    if (rd_done !== e_rsp || rv_done !== 1'b1) begin
      errors++;
      $display("FAIL clamp_rsp: got %h v%b want %h v1",
               rd_done, rv_done, e_rsp);
    end
    tdo_pat = {$urandom, $urandom};
    model(1, 0, $urandom);
    run_cmd(1, 0, $urandom);
    checks++;
    if (ncyc != 1 || o_tms !== 64'h0 || o_tdi !== 64'h0) begin
      errors++;
      $display("FAIL nop_seq: cyc %0d tms %h tdi %h want 1 0 0",
               ncyc, o_tms, o_tdi);
    end
    checks++;
    if (rv_done !== 1'b1 || rd_done !== 32'h0 || rv_after !== 1'b0) begin
      errors++;
      $display("FAIL nop_rsp: v%b %h after %b want v1 0 0",
               rv_done, rd_done, rv_after);
    end
  endtask

  task automatic test_random();
    int op, len;
    logic [31:0] d;
    for (int n = 0; n < 30; n++) begin
      op  = $urandom_range(0, 3);
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 1)
                                        : $urandom_range(2, 45);
      d   = $urandom;
      tdo_pat = {$urandom, $urandom};
      model(op, len, d);
      run_cmd(op, len, d);
      checks++;
      if (ncyc != e_ncyc || o_tms !== e_tms || o_tdi !== e_tdi) begin
        errors++;
        $display("FAIL rnd_seq op%0d len%0d: cyc %0d tms %h tdi %h",
                 op, len, ncyc, o_tms, o_tdi);
        $display("  want cyc %0d tms %h tdi %h", e_ncyc, e_tms, e_tdi);
      end
      checks++;
      if (nrsp_mid != 0 || rv_done !== e_rv || rd_done !== e_rsp ||
          rv_after !== 1'b0 || rdy_after !== 1'b1) begin
        errors++;
        $display("FAIL rnd_rsp op%0d len%0d: v%b %h got, v%b %h want",
                 op, len, rv_done, rd_done, e_rv, e_rsp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] seq;
    int nrdy, nrv;
    tdo_pat = {$urandom, $urandom};
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_len   = 6'd16;
    cmd_data  = $urandom;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tdo = tdo_pat[i];
      step();
    end
    #2;
    trst = 1'b0;
    last_rsp = '0;
    #1;
    checks++;
    if ({tms, tdi, cmd_ready, rsp_valid} !== 4'b1000 ||
        rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL midrst_outs: %b %h want 1000 0",
               {tms, tdi, cmd_ready, rsp_valid}, rsp_data);
    end
    nrv = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (rsp_valid || cmd_ready || !tms) nrv++;
    end
    checks++;
    if (nrv != 0) begin
      errors++;
      $display("FAIL midrst_hold: %0d bad cycles want 0", nrv);
    end
    trst = 1'b1;
    do_init(seq, nrdy, nrv);
    checks++;
    if (seq !== 64'h1f || nrdy != 0 || nrv != 0 ||
        cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_init: tms %h rdy %0d rv %0d end %b",
               seq, nrdy, nrv, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_shift_ir();
    test_shift_dr();
    test_back_to_back();
    test_boundaries();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_sequencer.md
Name: jtag_sequencer

Overview:
- Host-side JTAG master that turns command-level requests (reset TAP, shift IR, shift DR, run-idle) into the tms/tdi bit streams that drive the top-level TAP.
- Captures tdo into a response word.
- Sits directly upstream of the TAP port of top, shares its tck/trst, and replaces hand-built tms/tdi vectors.

Parameters:
- MAX_LEN, 32, maximum bits per shift command; also the cmd_data/rsp_data width.
- LEN_W, 6, cmd_len width; equals $clog2(MAX_LEN+1).

Ports:
- tck  input  1  JTAG clock; all block flops are falling-edge triggered.
- trst  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  block idle and able to accept.
- cmd_op  input  2  0=RESET, 1=SHIFT_IR, 2=SHIFT_DR, 3=RUNIDLE.
- cmd_len  input  LEN_W  shift length, or idle cycle count.
- cmd_data  input  MAX_LEN  tdi bits, shifted LSB first.
- rsp_valid  output  1  one-cycle pulse: shift result ready.
- rsp_data  output  MAX_LEN  captured tdo bits; bit k is the k-th shifted bit; unused MSBs are 0.
- tms  output  1  to TAP.
- tdi  output  1  to TAP.
- tdo  input  1  from TAP.

Behaviour:
- Cycle definition:
  - A cycle runs from one falling tck edge to the next.
  - tms/tdi are launched on the falling edge; the TAP samples them on the following rising edge.
  - tdo is sampled on the falling edge that ends the cycle, before the TAP updates it.
- Reset (trst=0, async):
  - tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0.
  - FSM enters INIT.
- INIT:
  - Begins on the first falling edge after trst release.
  - Launches tms 1,1,1,1,1,0 (6 cycles), leaving the TAP in Run-Test/Idle.
  - Then enters READY.
- READY:
  - cmd_ready=1, tms=0, tdi=0.
  - Handshake: command accepted on a falling edge with cmd_valid&&cmd_ready.
  - On the accepting edge, cmd_ready drops, the first tms bit of the sequence is launched, and op/len/data are latched.
  - Inputs are ignored while cmd_ready=0.
- Length handling:
  - cmd_len > MAX_LEN is clamped to MAX_LEN.
  - cmd_len=0 with SHIFT_IR, SHIFT_DR or RUNIDLE is a NOP: no tms activity (tms stays 0).
  - A NOP returns to READY on the next edge; for shift ops, rsp_valid pulses with rsp_data=0.
- Sequences (tms per cycle, starting on the accepting edge):
  - RESET: 1,1,1,1,1,0 (6 cycles). No response.
  - SHIFT_DR, length L: prefix 1,0,0; then L shift cycles with tms=0 except the last =1; suffix 1,0. Total L+5 cycles.
  - SHIFT_IR, length L: prefix 1,1,0,0; L shift cycles as for DR; suffix 1,0. Total L+6 cycles.
  - RUNIDLE, length L: L cycles of tms=0.
- Data path:
  - During shift cycle k (0-based), tdi=data[k].
  - tdo sampled at the end of cycle k is stored into rsp_data[k].
  - tdi=0 outside shift cycles.
- Completion:
  - On the edge after the last cycle of a sequence: cmd_ready=1.
  - For shift ops, rsp_valid=1 for exactly one cycle on that same edge.
  - rsp_data holds its value until the next shift op completes.
  - A new command may be accepted on that same edge (back-to-back, no gap).
- FSM states: INIT, READY, PRE, SHIFT, POST, RUN.
  - A 3-bit prefix/suffix counter and an LEN_W shift counter drive the transitions.
- Reset mid-operation:
  - Command is aborted; no rsp_valid.
  - Block re-runs INIT after release.

Decomposition:
- Package jtag_seq_pkg holds:
  - op enum (RESET/SHIFT_IR/SHIFT_DR/RUNIDLE).
  - FSM state enum.
  - Prefix/suffix tms pattern constants: DR_PRE=3'b100, IR_PRE=4'b1100, POST=2'b10, RST=6'b111110. Patterns are launched MSB first.
- One sub-module: jtag_seq_shifter.
  - MAX_LEN shift register: loads cmd_data, presents bit 0 as tdi, shifts in tdo at the MSB end, right-aligns the result on completion.

Test Plan:
- Reset then idle:
  - Stimulus: trst pulse low, then release.
  - Required: tms=1,1,1,1,1,0 on six falling edges; cmd_ready rises on the 7th; rsp_valid never asserted.
- SHIFT_IR, len=3, data=3'b010:
  - Required tms: 1,1,0,0,0,0,1,1,0.
  - Required tdi during shift cycles: 0,1,0.
  - rsp_valid pulses once; cmd_ready high 9 cycles after accept.
- SHIFT_DR, len=5, data=0:
  - Stimulus: TAP model returns tdo 0,1,1,0,1 over the shift cycles.
  - Required: rsp_data=32'h0000_0016; tms=1,0,0,0,0,0,0,1,1,0.
- Back-to-back:
  - Stimulus: RUNIDLE len=4 immediately followed by SHIFT_DR len=1; cmd_valid held high throughout.
  - Required: exactly 4 tms=0 cycles, then DR prefix with no gap; the second command is accepted on the completion edge.
- Boundaries:
  - SHIFT_DR with cmd_len=40: exactly 32 shift cycles.
  - SHIFT_IR with cmd_len=0: no tms activity; rsp_valid next edge with rsp_data=0.
- Mid-shift reset:
  - Stimulus: trst low during cycle 2 of a 16-bit DR shift.
  - Required: outputs immediately take reset values; no rsp_valid; INIT sequence replays after release.
